// File: rtl/ioctl_pkg.sv
// ioctl_pkg: command bytes shared by the ioctl download path
package ioctl_pkg;
  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
endpackage

// File: rtl/ioctl_fifo.sv
// ioctl_fifo: synchronous word buffer with flush; a write into a full buffer is taken only alongside a read
module ioctl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp, rp;
  logic         we, re;
  assign empty = wp == rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign we    = wr & (~full | rd);
  assign re    = rd & ~empty;
  assign dout  = mem[rp[PW-1:0]];
  always_ff @(posedge clk_sys)
    if (we) mem[wp[PW-1:0]] <= din;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/ioctl_loader.sv
// ioctl_loader: SPI-fed file download engine packing bytes into ioctl words for a clk_sys consumer
module ioctl_loader
  import ioctl_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 25,
  parameter int FIFO_DEPTH = 4,
  parameter bit BIG_ENDIAN = 0
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  output logic          ioctl_download,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [AW-1:0] ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  input  logic          ioctl_wait,
  output logic          ioctl_overflow,
  output logic [AW-1:0] ioctl_size
);
  localparam int NB = DW / 8;
  logic [1:0]         sck_s, ss_s, di_s;
  logic               sck_q, rise, byte_done;
  logic [2:0]         bit_cnt;
  logic [6:0]         sr;
  logic [1:0]         fb_cnt;
  logic [7:0]         cmd, byte_in;
  logic [AW-1:0]      cnt, waddr;
  logic [DW-1:0]      acc, acc_n;
  logic [1:0]         lane, pos;
  logic               last, is_data, do_idx, do_start, do_end, do_dat;
  logic               ending, push, pop, full, empty;
  logic [DW+AW-1:0]   fifo_q;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      sck_s <= '0;
      ss_s  <= '1;
      di_s  <= '0;
      sck_q <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], SPI_SCK};
      ss_s  <= {ss_s[0], SPI_SS2};
      di_s  <= {di_s[0], SPI_DI};
      sck_q <= sck_s[1];
    end
  always_comb begin
    rise      = sck_s[1] & ~sck_q & ~ss_s[1];
    byte_done = rise & (bit_cnt == 3'd7);
    byte_in   = {sr, di_s[1]};
    is_data   = byte_done & (fb_cnt != 2'd0);
    do_idx    = is_data & (cmd == UIO_FILE_INDEX) & (fb_cnt == 2'd1);
    do_start  = is_data & (cmd == UIO_FILE_TX) & (byte_in != 8'd0);
    do_end    = is_data & (cmd == UIO_FILE_TX) & (byte_in == 8'd0) & ioctl_download;
    do_dat    = is_data & (cmd == UIO_FILE_TX_DAT) & ioctl_download;
    lane      = 2'(cnt) & 2'(NB - 1);
    pos       = BIG_ENDIAN ? 2'(NB - 1) - lane : lane;
    last      = lane == 2'(NB - 1);
    acc_n     = acc | (DW'(byte_in) << (8 * pos));
    push      = (do_dat & last) | (do_end & (lane != 2'd0));
    pop       = ~empty & ~ioctl_wait & ~do_start;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      bit_cnt <= '0;
      sr      <= '0;
      fb_cnt  <= '0;
      cmd     <= '0;
    end else if (ss_s[1]) begin
      bit_cnt <= '0;
      fb_cnt  <= '0;
    end else if (rise) begin
      sr      <= {sr[5:0], di_s[1]};
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_done) fb_cnt <= (fb_cnt == 2'd2) ? 2'd2 : fb_cnt + 2'd1;
      if (byte_done && fb_cnt == 2'd0) cmd <= byte_in;
    end
  // Lane accumulator and address survive SS2 deassertion so a download can span frames
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_overflow <= 1'b0;
      ioctl_size     <= '0;
      cnt            <= '0;
      waddr          <= '0;
      acc            <= '0;
      ending         <= 1'b0;
    end else begin
      if (do_idx) ioctl_index <= byte_in;
      if (do_start) begin
        ioctl_download <= 1'b1;
        ioctl_overflow <= 1'b0;
        cnt            <= '0;
        waddr          <= '0;
        acc            <= '0;
        ending         <= 1'b0;
      end
      if (do_dat) begin
        cnt <= cnt + AW'(1);
        acc <= last ? '0 : acc_n;
        if (last) waddr <= waddr + AW'(NB);
      end
      if (do_end) begin
        ioctl_size <= cnt;
        acc        <= '0;
        ending     <= 1'b1;
      end
      if (push && full && !pop) ioctl_overflow <= 1'b1;
      if (ending && empty && !push) begin
        ioctl_download <= 1'b0;
        ending         <= 1'b0;
      end
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ioctl_wr   <= 1'b0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
    end else begin
      ioctl_wr <= pop;
      if (pop) {ioctl_dout, ioctl_addr} <= fifo_q;
    end
  ioctl_fifo #(.W(DW + AW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .flush   (do_start),
    .wr      (push),
    .din     ({do_dat ? acc_n : acc, waddr}),
    .rd      (pop),
    .dout    (fifo_q),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed SPI download vectors against a 16-bit little-endian and a 32-bit big-endian loader
module tb_ioctl_loader;
  logic clk_sys = 0, reset_n = 0, sck = 0, di = 0, ss16 = 1, ss32 = 1, wait16 = 0, wait32 = 0;
  logic dl16, wr16, ov16, dl32, wr32, ov32;
  logic [7:0] idx16, idx32;
  logic [24:0] addr16, size16, addr32, size32;
  logic [15:0] dout16;
  logic [31:0] dout32;
  int checks = 0, failures = 0;
  typedef struct { logic [24:0] a; logic [31:0] d; } wr_t;
  wr_t q16[$], q32[$];
  logic [7:0] fb[$];
  ioctl_loader #(.DW(16), .AW(25), .FIFO_DEPTH(4), .BIG_ENDIAN(0)) u16 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss16), .SPI_DI(di),
    .ioctl_download(dl16), .ioctl_index(idx16), .ioctl_wr(wr16), .ioctl_addr(addr16),
    .ioctl_dout(dout16), .ioctl_wait(wait16), .ioctl_overflow(ov16), .ioctl_size(size16));
  ioctl_loader #(.DW(32), .AW(25), .FIFO_DEPTH(4), .BIG_ENDIAN(1)) u32 (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(sck), .SPI_SS2(ss32), .SPI_DI(di),
    .ioctl_download(dl32), .ioctl_index(idx32), .ioctl_wr(wr32), .ioctl_addr(addr32),
    .ioctl_dout(dout32), .ioctl_wait(wait32), .ioctl_overflow(ov32), .ioctl_size(size32));
  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) begin
    if (wr16) q16.push_back('{addr16, 32'(dout16)});
    if (wr32) q32.push_back('{addr32, dout32});
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      di = b[i];
      #40 sck = 1;
      #40 sck = 0;
    end
  endtask
  task automatic frame(input bit big);
    if (big) ss32 = 0; else ss16 = 0;
    #100;
    foreach (fb[i]) spi_byte(fb[i]);
    #100;
    ss16 = 1;
    ss32 = 1;
    #100;
  endtask
  task automatic check_wr(input string tag, input bit big, input int i, input logic [24:0] a, input logic [31:0] d);
    if (big ? i < q32.size() : i < q16.size()) begin
      check({tag, "_addr"}, big ? q32[i].a : q16[i].a, a);
      check({tag, "_dout"}, big ? q32[i].d : q16[i].d, d);
    end else check({tag, "_missing"}, big ? q32.size() : q16.size(), i + 1);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_dl"}, dl16, 0);
    check({tag, "_wr"}, wr16, 0);
    check({tag, "_ov"}, ov16, 0);
    check({tag, "_addr"}, addr16, 0);
    check({tag, "_dout"}, dout16, 0);
    check({tag, "_size"}, size16, 0);
    check({tag, "_idx"}, idx16, 0);
  endtask
  initial begin
    #23;
    check_zero("rst");
    check("rst_dl32", dl32, 0);
    check("rst_size32", size32, 0);
    reset_n = 1;
    #50;
    fb = '{8'h55, 8'h03}; frame(0);
    check("t1_index", idx16, 8'h03);
    fb = '{8'h53, 8'h01}; frame(0);
    check("t1_dl_on", dl16, 1);
    fb = '{8'h54, 8'h11, 8'h22, 8'h33, 8'h44}; frame(0);
    fb = '{8'h53, 8'h00}; frame(0);
    repeat (20) @(posedge clk_sys);
    check("t1_nwr", q16.size(), 2);
    check_wr("t1_w0", 0, 0, 25'd0, 32'h2211);
    check_wr("t1_w1", 0, 1, 25'd2, 32'h4433);
    check("t1_size", size16, 4);
    check("t1_dl_off", dl16, 0);
    check("t1_ov", ov16, 0);
    fb = '{8'h53, 8'h01}; frame(1);
    fb = '{8'h54, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}; frame(1);
    fb = '{8'h53, 8'h00}; frame(1);
    repeat (20) @(posedge clk_sys);
    check("t2_nwr", q32.size(), 2);
    check_wr("t2_w0", 1, 0, 25'd0, 32'hAABBCCDD);
    check_wr("t2_w1", 1, 1, 25'd4, 32'hEE000000);
    check("t2_size", size32, 5);
    check("t2_dl_off", dl32, 0);
    q16.delete();
    wait16 = 1;
    fb = '{8'h53, 8'h01}; frame(0);
    check("t3_ov_clear", ov16, 0);
    fb = '{8'h54, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    frame(0);
    check("t3_ov", ov16, 1);
    check("t3_nwr_wait", q16.size(), 0);
    wait16 = 0;
    repeat (20) @(posedge clk_sys);
    check("t3_nwr", q16.size(), 4);
    for (int i = 0; i < 4; i++)
      check_wr($sformatf("t3_w%0d", i), 0, i, 25'(2 * i), 32'({8'(2 * i + 2), 8'(2 * i + 1)}));
    fb = '{8'h53, 8'h00}; frame(0);
    repeat (10) @(posedge clk_sys);
    check("t3_size", size16, 12);
    check("t3_dl_off", dl16, 0);
    q16.delete();
    fb = '{8'h53, 8'h01}; frame(0);
    check("t4_ov_clear", ov16, 0);
    fb = '{8'h54, 8'h11}; frame(0);
    check("t4_nwr_half", q16.size(), 0);
    fb = '{8'h54, 8'h22}; frame(0);
    fb = '{8'h53, 8'h00}; frame(0);
    repeat (10) @(posedge clk_sys);
    check("t4_nwr", q16.size(), 1);
    check_wr("t4_w0", 0, 0, 25'd0, 32'h2211);
    check("t4_size", size16, 2);
    fb = '{8'h53, 8'h01}; frame(0);
    fb = '{8'h54, 8'hA1, 8'hA2, 8'hA3}; frame(0);
    check("t5_dl_pre", dl16, 1);
    reset_n = 0;
    #20;
    check_zero("t5_rst");
    reset_n = 1;
    #50;
    q16.delete();
    fb = '{8'h54, 8'h77, 8'h88}; frame(0);
    check("t5_ignored", q16.size(), 0);
    fb = '{8'h53, 8'h01}; frame(0);
    fb = '{8'h54, 8'h55, 8'h66}; frame(0);
    repeat (10) @(posedge clk_sys);
    check("t5_nwr", q16.size(), 1);
    check_wr("t5_w0", 0, 0, 25'd0, 32'h6655);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
